// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//   Issue stage in front of the ALU. Selects operand sources (rs1/PC and
//   rs2/imm), resolves read-after-write hazards against the EX and MEM
//   stages, and registers {op, operand_a, operand_b, rd} behind a two-entry
//   valid/ready skid buffer so the ALU always sees stable registered values.
//
//   Optional feature macro: ALU_OPSTAGE_FWD_EN
//     defined     : EX/MEM bypass; stall only on an EX match with ex_pending_i.
//     not defined : no bypass; stall on any used rs matching a write-enabled
//                   EX or MEM destination (interlock until writeback).
//
// Ports
//   clk_i, rst_i         clock (rising edge), async active-high reset
//   flush_i              drop all held and same-cycle incoming ops
//   in_valid_i/in_ready_o  upstream handshake
//   in_op_i .. in_rd_i   decoded op, register data, immediate, PC, selects
//   ex_* / mem_*         downstream writer info used for bypass / interlock
//   out_valid_o/out_ready_i  ALU-side handshake
//   out_op_o, out_a_o, out_b_o, out_rd_o  registered op towards the ALU
// ---------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [3:0]            in_op_i,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr_i,
  input  logic [XLEN-1:0]       in_rs1_data_i,
  input  logic [XLEN-1:0]       in_rs2_data_i,
  input  logic [XLEN-1:0]       in_imm_i,
  input  logic [XLEN-1:0]       in_pc_i,
  input  logic                  in_use_pc_i,
  input  logic                  in_use_imm_i,
  input  logic [REG_ADDR_W-1:0] in_rd_i,
  input  logic                  ex_wr_en_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [XLEN-1:0]       ex_data_i,
  input  logic                  ex_pending_i,
  input  logic                  mem_wr_en_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic [XLEN-1:0]       mem_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [3:0]            out_op_o,
  output logic [XLEN-1:0]       out_a_o,
  output logic [XLEN-1:0]       out_b_o,
  output logic [REG_ADDR_W-1:0] out_rd_o
);

  localparam logic [3:0] ALU_NONE = 4'd0;

  // hazard detection
  logic            w_use_rs1, w_use_rs2;
  logic            w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2;
  logic            w_stall, w_accept, w_main_free;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_a, w_b;

  // main (output) entry and skid entry
  logic                  r_main_valid, r_skid_valid, r_in_ready;
  logic [3:0]            r_main_op, r_skid_op;
  logic [XLEN-1:0]       r_main_a, r_main_b, r_skid_a, r_skid_b;
  logic [REG_ADDR_W-1:0] r_main_rd, r_skid_rd;

  // A source only matters when it is actually selected; x0 never hazards.
  assign w_use_rs1  = ~in_use_pc_i  & (in_rs1_addr_i != {REG_ADDR_W{1'b0}});
  assign w_use_rs2  = ~in_use_imm_i & (in_rs2_addr_i != {REG_ADDR_W{1'b0}});
  assign w_ex_hit1  = ex_wr_en_i  & (ex_rd_i  == in_rs1_addr_i);
  assign w_ex_hit2  = ex_wr_en_i  & (ex_rd_i  == in_rs2_addr_i);
  assign w_mem_hit1 = mem_wr_en_i & (mem_rd_i == in_rs1_addr_i);
  assign w_mem_hit2 = mem_wr_en_i & (mem_rd_i == in_rs2_addr_i);

  // Register value resolution and stall generation
  always_comb begin
    w_rs1_val = {XLEN{1'b0}};
    w_rs2_val = {XLEN{1'b0}};
    w_stall   = 1'b0;
`ifdef ALU_OPSTAGE_FWD_EN
    // EX is younger than MEM, so it wins when both target the same register.
    if (in_rs1_addr_i == {REG_ADDR_W{1'b0}}) begin
      w_rs1_val = {XLEN{1'b0}};
    end else if (w_ex_hit1) begin
      w_rs1_val = ex_data_i;
    end else if (w_mem_hit1) begin
      w_rs1_val = mem_data_i;
    end else begin
      w_rs1_val = in_rs1_data_i;
    end
    if (in_rs2_addr_i == {REG_ADDR_W{1'b0}}) begin
      w_rs2_val = {XLEN{1'b0}};
    end else if (w_ex_hit2) begin
      w_rs2_val = ex_data_i;
    end else if (w_mem_hit2) begin
      w_rs2_val = mem_data_i;
    end else begin
      w_rs2_val = in_rs2_data_i;
    end
    w_stall = in_valid_i & ex_pending_i &
              ((w_use_rs1 & w_ex_hit1) | (w_use_rs2 & w_ex_hit2));
`else
    w_rs1_val = (in_rs1_addr_i == {REG_ADDR_W{1'b0}}) ? {XLEN{1'b0}} : in_rs1_data_i;
    w_rs2_val = (in_rs2_addr_i == {REG_ADDR_W{1'b0}}) ? {XLEN{1'b0}} : in_rs2_data_i;
    w_stall   = in_valid_i &
                ((w_use_rs1 & (w_ex_hit1 | w_mem_hit1)) |
                 (w_use_rs2 & (w_ex_hit2 | w_mem_hit2)));
`endif
  end

`ifndef ALU_OPSTAGE_FWD_EN
  // Bypass data is not consumed without forwarding.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{ex_data_i, mem_data_i, ex_pending_i};
`endif

  assign w_a = in_use_pc_i  ? in_pc_i  : w_rs1_val;
  assign w_b = in_use_imm_i ? in_imm_i : w_rs2_val;

  // r_in_ready tracks "skid not full"; a hazard stall masks it combinationally
  // so the producer sees the stall in the same cycle.
  assign in_ready_o  = r_in_ready & ~w_stall;
  assign w_accept    = in_valid_i & in_ready_o & ~flush_i;
  assign w_main_free = ~r_main_valid | out_ready_i;

  // Two-entry skid buffer: main drives the outputs, skid catches one op
  // accepted while main is blocked.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main_valid <= 1'b0;
      r_main_op    <= ALU_NONE;
      r_main_a     <= {XLEN{1'b0}};
      r_main_b     <= {XLEN{1'b0}};
      r_main_rd    <= {REG_ADDR_W{1'b0}};
      r_skid_valid <= 1'b0;
      r_skid_op    <= ALU_NONE;
      r_skid_a     <= {XLEN{1'b0}};
      r_skid_b     <= {XLEN{1'b0}};
      r_skid_rd    <= {REG_ADDR_W{1'b0}};
      r_in_ready   <= 1'b1;
    end else if (flush_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        // skid is full here, so in_ready was low and nothing new is accepted
        r_main_valid <= 1'b1;
        r_main_op    <= r_skid_op;
        r_main_a     <= r_skid_a;
        r_main_b     <= r_skid_b;
        r_main_rd    <= r_skid_rd;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_accept) begin
        r_main_valid <= 1'b1;
        r_main_op    <= in_op_i;
        r_main_a     <= w_a;
        r_main_b     <= w_b;
        r_main_rd    <= in_rd_i;
      end else begin
        // outputs keep their last values when empty
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_op    <= in_op_i;
      r_skid_a     <= w_a;
      r_skid_b     <= w_b;
      r_skid_rd    <= in_rd_i;
      r_in_ready   <= 1'b0;
    end
  end

  assign out_valid_o = r_main_valid;
  assign out_op_o    = r_main_op;
  assign out_a_o     = r_main_a;
  assign out_b_o     = r_main_b;
  assign out_rd_o    = r_main_rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } exp_t;

  logic        clk, rst, flush;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic        in_use_pc, in_use_imm;
  logic        ex_wr_en, ex_pending, mem_wr_en;
  logic [4:0]  ex_rd, mem_rd;
  logic [31:0] ex_data, mem_data;
  logic        out_valid, out_ready;
  logic [3:0]  out_op;
  logic [31:0] out_a, out_b;
  logic [4:0]  out_rd;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc;

  alu_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op),
    .in_rs1_addr_i(in_rs1_addr), .in_rs2_addr_i(in_rs2_addr),
    .in_rs1_data_i(in_rs1_data), .in_rs2_data_i(in_rs2_data),
    .in_imm_i(in_imm), .in_pc_i(in_pc), .in_use_pc_i(in_use_pc),
    .in_use_imm_i(in_use_imm), .in_rd_i(in_rd),
    .ex_wr_en_i(ex_wr_en), .ex_rd_i(ex_rd), .ex_data_i(ex_data),
    .ex_pending_i(ex_pending), .mem_wr_en_i(mem_wr_en), .mem_rd_i(mem_rd),
    .mem_data_i(mem_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_op_o(out_op), .out_a_o(out_a), .out_b_o(out_b), .out_rd_o(out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.rd = rd;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_op(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic upc, input logic uimm,
                        input logic [4:0] rd);
    in_op = op; in_rs1_addr = rs1; in_rs2_addr = rs2; in_rs1_data = d1;
    in_rs2_data = d2; in_imm = imm; in_pc = pc; in_use_pc = upc;
    in_use_imm = uimm; in_rd = rd; in_valid = 1'b1;
  endtask

  // Waits (bounded) for the currently driven op to be accepted; pushes expectation.
  task automatic issue(input exp_t e, output int ncyc);
    bit acc;
    acc  = 1'b0;
    ncyc = 0;
    while (!acc && ncyc < 20) begin
      @(negedge clk);
      ncyc++;
      if (in_ready && !flush) begin
        sb_q.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: actual=not_accepted required=accepted");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every transfer to the ALU must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL out_txn: actual op=%0h a=%0h b=%0h rd=%0d required=no_output",
                 out_op, out_a, out_b, out_rd);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e !== {out_op, out_a, out_b, out_rd}) begin
          failures++;
          $display("FAIL out_txn: actual op=%0h a=%0h b=%0h rd=%0d required op=%0h a=%0h b=%0h rd=%0d",
                   out_op, out_a, out_b, out_rd, mon_e.op, mon_e.a, mon_e.b, mon_e.rd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_op(ALU_NONE, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    in_valid = 1'b0;
    ex_wr_en = 1'b0; ex_rd = 5'd0; ex_data = 32'd0; ex_pending = 1'b0;
    mem_wr_en = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    #1 rst = 1'b1;
    #20;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_op",    {28'd0, out_op},    {28'd0, ALU_NONE});
    check("rst_out_a",     out_a,              32'd0);
    check("rst_out_b",     out_b,              32'd0);
    check("rst_out_rd",    {27'd0, out_rd},    32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: basic ADD, latency one
    set_op(ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 32'h100, 1'b0, 1'b0, 5'd10);
    issue(mk(ALU_ADD, 32'd5, 32'd7, 5'd10), cyc);
    check("add_accept_cycles", cyc, 32'd1);
    check("add_latency_valid", {31'd0, out_valid}, 32'd1);
    // PC and immediate selects
    set_op(ALU_SUB, 5'd1, 5'd2, 32'd5, 32'd7, 32'hFFFF_FFFC, 32'h200, 1'b1, 1'b1, 5'd11);
    issue(mk(ALU_SUB, 32'h200, 32'hFFFF_FFFC, 5'd11), cyc);
    // x0 always reads as zero regardless of register file data
    set_op(ALU_XOR, 5'd0, 5'd0, 32'hDEAD, 32'hBEEF, 32'd0, 32'd0, 1'b0, 1'b0, 5'd12);
    issue(mk(ALU_XOR, 32'd0, 32'd0, 5'd12), cyc);
    idle(2);
    check("empty_valid",    {31'd0, out_valid}, 32'd0);
    check("empty_keep_rd",  {27'd0, out_rd},    32'd12);

    // 4: backpressure, skid fill, in-order drain
    out_ready = 1'b0;
    set_op(ALU_AND, 5'd1, 5'd2, 32'hF0, 32'h3C, 32'd0, 32'd0, 1'b0, 1'b0, 5'd1);
    issue(mk(ALU_AND, 32'hF0, 32'h3C, 5'd1), cyc);
    set_op(ALU_OR, 5'd3, 5'd4, 32'h11, 32'h22, 32'd0, 32'd0, 1'b0, 1'b0, 5'd2);
    issue(mk(ALU_OR, 32'h11, 32'h22, 5'd2), cyc);
    set_op(ALU_ADD, 5'd5, 5'd6, 32'h33, 32'h44, 32'd0, 32'd0, 1'b0, 1'b0, 5'd3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("full_in_ready", {31'd0, in_ready},  32'd0);
      check("held_out_a",    out_a,              32'hF0);
      check("held_valid",    {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    issue(mk(ALU_ADD, 32'h33, 32'h44, 5'd3), cyc);
    idle(3);
    check("drain_queue_empty", sb_q.size(), 32'd0);

    // 5: flush with two held entries and a same-cycle input
    out_ready = 1'b0;
    set_op(ALU_SUB, 5'd1, 5'd2, 32'hA, 32'hB, 32'd0, 32'd0, 1'b0, 1'b0, 5'd4);
    issue(mk(ALU_SUB, 32'hA, 32'hB, 5'd4), cyc);
    set_op(ALU_XOR, 5'd1, 5'd2, 32'hC, 32'hD, 32'd0, 32'd0, 1'b0, 1'b0, 5'd5);
    issue(mk(ALU_XOR, 32'hC, 32'hD, 5'd5), cyc);
    set_op(ALU_AND, 5'd1, 5'd2, 32'hE, 32'hF, 32'd0, 32'd0, 1'b0, 1'b0, 5'd6);
    flush = 1'b1;
    @(negedge clk);
    sb_q.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready",  {31'd0, in_ready},  32'd1);
    out_ready = 1'b1;
    idle(3);
    set_op(ALU_OR, 5'd7, 5'd8, 32'h70, 32'h80, 32'd0, 32'd0, 1'b0, 1'b0, 5'd7);
    issue(mk(ALU_OR, 32'h70, 32'h80, 5'd7), cyc);
    idle(2);
    check("post_flush_queue", sb_q.size(), 32'd0);

`ifdef ALU_OPSTAGE_FWD_EN
    // 2: bypass priority
    ex_wr_en = 1'b1; ex_rd = 5'd3; ex_data = 32'h10;
    mem_wr_en = 1'b1; mem_rd = 5'd3; mem_data = 32'h20;
    set_op(ALU_ADD, 5'd3, 5'd2, 32'h99, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 5'd8);
    issue(mk(ALU_ADD, 32'h10, 32'd7, 5'd8), cyc);
    ex_wr_en = 1'b0;
    issue(mk(ALU_ADD, 32'h20, 32'd7, 5'd8), cyc);
    mem_wr_en = 1'b0;
    ex_wr_en = 1'b1; ex_rd = 5'd0; ex_data = 32'd9;
    set_op(ALU_ADD, 5'd0, 5'd2, 32'h0, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 5'd8);
    issue(mk(ALU_ADD, 32'd0, 32'd7, 5'd8), cyc);
    idle(1);
    // 3: pending load stall
    ex_wr_en = 1'b1; ex_rd = 5'd4; ex_pending = 1'b1; ex_data = 32'hBAD;
    set_op(ALU_SUB, 5'd4, 5'd2, 32'h1, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 5'd9);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("pending_stall_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    ex_pending = 1'b0; ex_data = 32'h33;
    issue(mk(ALU_SUB, 32'h33, 32'd7, 5'd9), cyc);
    check("pending_release_cycles", cyc, 32'd1);
    ex_pending = 1'b1;
    set_op(ALU_SUB, 5'd1, 5'd4, 32'd5, 32'h1, 32'h44, 32'd0, 1'b0, 1'b1, 5'd9);
    issue(mk(ALU_SUB, 32'd5, 32'h44, 5'd9), cyc);
    check("imm_no_stall_cycles", cyc, 32'd1);
    ex_pending = 1'b0; ex_wr_en = 1'b0;
    idle(2);
`else
    // 6: MEM interlock without forwarding
    mem_wr_en = 1'b1; mem_rd = 5'd5; mem_data = 32'hBAD;
    set_op(ALU_OR, 5'd1, 5'd5, 32'd1, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd13);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mem_stall_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    mem_wr_en = 1'b0; in_rs2_data = 32'h77;
    issue(mk(ALU_OR, 32'd1, 32'h77, 5'd13), cyc);
    check("mem_release_cycles", cyc, 32'd1);
    // EX match on an unused rs1 (PC selected) does not stall
    ex_wr_en = 1'b1; ex_rd = 5'd6; ex_data = 32'hBAD;
    set_op(ALU_ADD, 5'd6, 5'd2, 32'h66, 32'd4, 32'd0, 32'h300, 1'b1, 1'b0, 5'd14);
    issue(mk(ALU_ADD, 32'h300, 32'd4, 5'd14), cyc);
    check("unused_rs_no_stall", cyc, 32'd1);
    set_op(ALU_ADD, 5'd6, 5'd2, 32'h66, 32'd4, 32'd0, 32'h300, 1'b0, 1'b0, 5'd14);
    @(negedge clk);
    check("ex_stall_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    ex_wr_en = 1'b0;
    issue(mk(ALU_ADD, 32'h66, 32'd4, 5'd14), cyc);
    idle(2);
`endif

    // asynchronous reset while an op is held
    out_ready = 1'b0;
    set_op(ALU_XOR, 5'd1, 5'd2, 32'h5, 32'h6, 32'd0, 32'd0, 1'b0, 1'b0, 5'd15);
    issue(mk(ALU_XOR, 32'h5, 32'h6, 5'd15), cyc);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_ready", {31'd0, in_ready},  32'd1);
    check("async_rst_op",    {28'd0, out_op},    {28'd0, ALU_NONE});
    sb_q.delete();
    #3 rst = 1'b0;
    out_ready = 1'b1;
    idle(2);
    check("final_queue_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
